// File: rtl/fc_stream_tx_if.sv
// fc_stream_tx bus bundle: config, byte stream, FC front end and result port.
// Optional FC_STREAM_TX_RELU_EN lives in the core; this file is unaffected.
interface fc_stream_tx_if #(
  parameter int BIAS_W = 25,
  parameter int RES_W  = 21
);
  logic              cfg_start;
  logic [BIAS_W-1:0] cfg_bias;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_d_byte;
  logic [7:0]        in_w_byte;
  logic [63:0]       d_64bit;
  logic [63:0]       w_64bit;
  logic [BIAS_W-1:0] bias;
  logic              word_strobe;
  logic [RES_W-1:0]  final_out;
  logic              cyc_done;
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic              busy;
  logic              err_spurious;

  modport master (
    output cfg_start, cfg_bias, in_valid, in_d_byte, in_w_byte,
    output final_out, cyc_done, res_ready,
    input  in_ready, d_64bit, w_64bit, bias, word_strobe,
    input  res_valid, res_data, busy, err_spurious
  );

  modport slave (
    input  cfg_start, cfg_bias, in_valid, in_d_byte, in_w_byte,
    input  final_out, cyc_done, res_ready,
    output in_ready, d_64bit, w_64bit, bias, word_strobe,
    output res_valid, res_data, busy, err_spurious
  );
endinterface

// File: rtl/fc_stream_tx.sv
// Byte-pair packer feeding the FC front end; returns one neuron result.
// FC_STREAM_TX_RELU_EN clamps negative results to zero at capture.
module fc_stream_tx #(
  parameter int WORDS_PER_NEURON = 64,
  parameter int BIAS_W           = 25,
  parameter int RES_W            = 21
) (
  input  logic              clk,
  input  logic              rstn,
  fc_stream_tx_if.slave     bus
);

  localparam int WC_W = (WORDS_PER_NEURON > 1) ?
                        $clog2(WORDS_PER_NEURON) : 1;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS_PER_NEURON - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_WAIT   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [2:0]        r_byte_cnt;
  logic [WC_W-1:0]   r_word_cnt;
  logic [63:0]       r_d_pack;
  logic [63:0]       r_w_pack;
  logic [63:0]       r_d_out;
  logic [63:0]       r_w_out;
  logic              r_strobe;
  logic [BIAS_W-1:0] r_bias;
  logic              r_res_valid;
  logic [RES_W-1:0]  r_res_data;
  logic              r_err;

  logic w_in_ready;
  logic w_busy;
  logic w_start;
  logic w_acc;
  logic w_issue;
  logic w_cap;
  logic w_hs;
  logic w_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.cfg_start)           w_nxt = S_FILL;
      S_FILL:   if (w_issue && w_last)       w_nxt = S_WAIT;
      S_WAIT:   if (bus.cyc_done)            w_nxt = S_RESULT;
      S_RESULT: if (w_hs)                    w_nxt = S_IDLE;
      default:                               w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = (r_state == S_FILL);
    w_busy     = (r_state != S_IDLE);
    w_start    = (r_state == S_IDLE) && bus.cfg_start;
    w_acc      = w_in_ready && bus.in_valid;
    w_issue    = w_acc && (r_byte_cnt == 3'd7);
    w_last     = (r_word_cnt == LAST_WORD);
    w_cap      = (r_state == S_WAIT) && bus.cyc_done;
    w_hs       = (r_state == S_RESULT) && r_res_valid && bus.res_ready;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
      r_d_pack   <= '0;
      r_w_pack   <= '0;
      r_bias     <= '0;
    end else begin
      if (w_start) begin
        r_bias     <= bus.cfg_bias;
        r_byte_cnt <= '0;
        r_word_cnt <= '0;
      end
      if (w_acc) begin
        r_d_pack[{r_byte_cnt, 3'b000} +: 8] <= bus.in_d_byte;
        r_w_pack[{r_byte_cnt, 3'b000} +: 8] <= bus.in_w_byte;
        r_byte_cnt <= r_byte_cnt + 3'd1;
      end
      if (w_issue) r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

  // Idle cycles drive zero words so the accumulator sees zero products.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_d_out  <= '0;
      r_w_out  <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_issue;
      r_d_out  <= w_issue ? {bus.in_d_byte, r_d_pack[55:0]} : 64'd0;
      r_w_out  <= w_issue ? {bus.in_w_byte, r_w_pack[55:0]} : 64'd0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_cap) begin
        r_res_valid <= 1'b1;
`ifdef FC_STREAM_TX_RELU_EN
        r_res_data  <= bus.final_out[RES_W-1] ? '0 : bus.final_out;
`else
        r_res_data  <= bus.final_out;
`endif
      end else if (w_hs) begin
        r_res_valid <= 1'b0;
      end
      if (bus.cyc_done && (r_state != S_WAIT)) r_err <= 1'b1;
      else if (w_start)                        r_err <= 1'b0;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.busy         = w_busy;
  assign bus.d_64bit      = r_d_out;
  assign bus.w_64bit      = r_w_out;
  assign bus.word_strobe  = r_strobe;
  assign bus.bias         = r_bias;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_data     = r_res_data;
  assign bus.err_spurious = r_err;

endmodule

// File: tb/tb_fc_stream_tx.sv
// Directed bench for fc_stream_tx with two words per neuron.
// Honours FC_STREAM_TX_RELU_EN when checking negative results.
module tb_fc_stream_tx;

  localparam int BW = 25;
  localparam int RW = 21;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_pass;

  fc_stream_tx_if #(.BIAS_W(BW), .RES_W(RW)) ifc ();

  fc_stream_tx #(
    .WORDS_PER_NEURON (2),
    .BIAS_W           (BW),
    .RES_W            (RW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pack(logic [7:0] base);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = base + 8'(k);
    return v;
  endfunction

  task automatic start(logic [BW-1:0] b);
    ifc.cfg_start = 1'b1;
    ifc.cfg_bias  = b;
    tick();
    ifc.cfg_start = 1'b0;
  endtask

  task automatic fill16(logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      ifc.in_valid  = 1'b1;
      ifc.in_d_byte = base + 8'(i);
      ifc.in_w_byte = base + 8'(i);
      tick();
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic finish_neuron(logic [RW-1:0] r);
    ifc.final_out = r;
    ifc.cyc_done  = 1'b1;
    tick();
    ifc.cyc_done  = 1'b0;
  endtask

  initial begin
    logic [63:0] exp_d;
    logic [63:0] exp_w;
    logic        exp_s;
    n_chk = 0;
    n_pass = 0;
    rstn = 1'b0;
    ifc.cfg_start = 1'b0;
    ifc.cfg_bias  = '0;
    ifc.in_valid  = 1'b0;
    ifc.in_d_byte = '0;
    ifc.in_w_byte = '0;
    ifc.final_out = '0;
    ifc.cyc_done  = 1'b0;
    ifc.res_ready = 1'b0;

    #12;
    check("rst_busy", 64'(ifc.busy), 64'd0);
    check("rst_in_ready", 64'(ifc.in_ready), 64'd0);
    check("rst_d", ifc.d_64bit, 64'd0);
    check("rst_strobe", 64'(ifc.word_strobe), 64'd0);
    check("rst_res_valid", 64'(ifc.res_valid), 64'd0);
    check("rst_err", 64'(ifc.err_spurious), 64'd0);
    rstn = 1'b1;
    tick();

    // Neuron 1: continuous stream
    start(25'd100);
    check("n1_busy", 64'(ifc.busy), 64'd1);
    check("n1_in_ready", 64'(ifc.in_ready), 64'd1);
    check("n1_bias", 64'(ifc.bias), 64'd100);
    for (int i = 0; i < 16; i++) begin
      ifc.in_valid  = 1'b1;
      ifc.in_d_byte = 8'(i + 1);
      ifc.in_w_byte = 8'(i + 8'h11);
      tick();
      exp_d = (i == 7)  ? 64'h0807060504030201 :
              (i == 15) ? 64'h100F0E0D0C0B0A09 : 64'd0;
      exp_w = (i == 7)  ? 64'h1817161514131211 :
              (i == 15) ? 64'h201F1E1D1C1B1A19 : 64'd0;
      exp_s = (i == 7) || (i == 15);
      check("n1_strobe", 64'(ifc.word_strobe), 64'(exp_s));
      check("n1_d", ifc.d_64bit, exp_d);
      check("n1_w", ifc.w_64bit, exp_w);
      check("n1_bias_hold", 64'(ifc.bias), 64'd100);
    end
    check("n1_in_ready_drop", 64'(ifc.in_ready), 64'd0);
    ifc.in_valid = 1'b0;
    tick();
    check("n1_bubble_strobe", 64'(ifc.word_strobe), 64'd0);
    check("n1_bubble_d", ifc.d_64bit, 64'd0);
    finish_neuron(21'h00ABC);
    check("n1_res_valid", 64'(ifc.res_valid), 64'd1);
    check("n1_res_data", 64'(ifc.res_data), 64'h00ABC);
    check("n1_err", 64'(ifc.err_spurious), 64'd0);
    ifc.res_ready = 1'b1;
    tick();
    ifc.res_ready = 1'b0;
    check("n1_res_clear", 64'(ifc.res_valid), 64'd0);
    check("n1_idle", 64'(ifc.busy), 64'd0);
    check("n1_res_hold", 64'(ifc.res_data), 64'h00ABC);
    check("n1_bias_kept", 64'(ifc.bias), 64'd100);

    // Neuron 2: stalled stream with a spurious cyc_done in FILL
    start(25'd5);
    for (int j = 0; j < 32; j++) begin
      ifc.in_valid  = (j % 2 == 0);
      ifc.in_d_byte = 8'h21 + 8'(j / 2);
      ifc.in_w_byte = 8'h41 + 8'(j / 2);
      ifc.cyc_done  = (j == 4);
      tick();
      exp_s = (j % 2 == 0) && ((j / 2) % 8 == 7);
      exp_d = exp_s ? pack(8'h21 + 8'(8 * (j / 16))) : 64'd0;
      exp_w = exp_s ? pack(8'h41 + 8'(8 * (j / 16))) : 64'd0;
      check("n2_strobe", 64'(ifc.word_strobe), 64'(exp_s));
      check("n2_d", ifc.d_64bit, exp_d);
      check("n2_w", ifc.w_64bit, exp_w);
      if (j == 4) begin
        check("n2_err_set", 64'(ifc.err_spurious), 64'd1);
        check("n2_still_fill", 64'(ifc.in_ready), 64'd1);
      end
    end
    ifc.cyc_done = 1'b0;
    ifc.in_valid = 1'b0;
    check("n2_wait", 64'(ifc.in_ready), 64'd0);
    start(25'd999);
    check("n2_start_ignored_bias", 64'(ifc.bias), 64'd5);
    check("n2_start_ignored_busy", 64'(ifc.busy), 64'd1);
    check("n2_start_ignored_rv", 64'(ifc.res_valid), 64'd0);
    finish_neuron(21'h00001);
    ifc.res_ready = 1'b1;
    tick();
    ifc.res_ready = 1'b0;
    check("n2_idle", 64'(ifc.busy), 64'd0);

    // Neuron 3: err cleared, back-pressure, then same-cycle start+ready
    start(25'd77);
    check("n3_err_clear", 64'(ifc.err_spurious), 64'd0);
    fill16(8'h50);
    finish_neuron(21'h12345);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("n3_bp_valid", 64'(ifc.res_valid), 64'd1);
      check("n3_bp_data", 64'(ifc.res_data), 64'h12345);
      check("n3_bp_in_ready", 64'(ifc.in_ready), 64'd0);
    end
    finish_neuron(21'h0BEEF);
    check("n3_err_result", 64'(ifc.err_spurious), 64'd1);
    check("n3_data_kept", 64'(ifc.res_data), 64'h12345);
    ifc.res_ready = 1'b1;
    start(25'd3);
    ifc.res_ready = 1'b0;
    check("n3_hs_idle", 64'(ifc.busy), 64'd0);
    check("n3_hs_bias", 64'(ifc.bias), 64'd77);
    check("n3_hs_rv", 64'(ifc.res_valid), 64'd0);

    // Asynchronous reset after 5 bytes
    start(25'd7);
    for (int i = 0; i < 5; i++) begin
      ifc.in_valid  = 1'b1;
      ifc.in_d_byte = 8'hE0 + 8'(i);
      ifc.in_w_byte = 8'hF0 + 8'(i);
      tick();
    end
    ifc.in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("ar_busy", 64'(ifc.busy), 64'd0);
    check("ar_in_ready", 64'(ifc.in_ready), 64'd0);
    check("ar_bias", 64'(ifc.bias), 64'd0);
    check("ar_err", 64'(ifc.err_spurious), 64'd0);
    check("ar_res_data", 64'(ifc.res_data), 64'd0);
    #3 rstn = 1'b1;
    tick();
    check("ar_no_issue", 64'(ifc.word_strobe), 64'd0);
    start(25'd9);
    for (int i = 0; i < 8; i++) begin
      ifc.in_valid  = 1'b1;
      ifc.in_d_byte = (i == 0) ? 8'hAA : 8'(i);
      ifc.in_w_byte = (i == 0) ? 8'hBB : 8'(i);
      tick();
    end
    ifc.in_valid = 1'b0;
    check("ar_repack_strobe", 64'(ifc.word_strobe), 64'd1);
    check("ar_repack_d", ifc.d_64bit, 64'h07060504030201AA);
    check("ar_repack_w", ifc.w_64bit, 64'h07060504030201BB);
    for (int i = 0; i < 8; i++) begin
      ifc.in_valid = 1'b1;
      tick();
    end
    ifc.in_valid = 1'b0;
    finish_neuron(21'h1FFFFF);
`ifdef FC_STREAM_TX_RELU_EN
    check("relu_neg", 64'(ifc.res_data), 64'd0);
`else
    check("raw_neg", 64'(ifc.res_data), 64'h1FFFFF);
`endif
    ifc.res_ready = 1'b1;
    tick();
    ifc.res_ready = 1'b0;

    start(25'd11);
    fill16(8'h01);
    finish_neuron(21'h000123);
    check("pos_res", 64'(ifc.res_data), 64'h000123);
    check("pos_rv", 64'(ifc.res_valid), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
